fetch_unit: RTL

//   Parametrised instruction-fetch front end for the MIPS core. It owns the PC,

---
 rtl/fetch_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the combinational instruction
// memory, buffers fetched words in a small FIFO toward decode, and resolves redirects.
module fetch_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_en,
   input  logic [31:0]       imem_rdata,
   output logic              dec_valid,
   output logic [31:0]       dec_instr,
   output logic [ADDR_W-1:0] dec_pc4,
   input  logic              dec_ready,
   input  logic              redir_valid,
   input  logic [1:0]        redir_kind,
   input  logic [ADDR_W-1:0] redir_pc4,
   input  logic [15:0]       redir_imm,
   input  logic [25:0]       redir_idx,
   input  logic [ADDR_W-1:0] redir_reg,
   output logic [15:0]       redir_count
);

   localparam int unsigned       PTR_W    = $clog2(DEPTH);
   localparam int unsigned       CNT_W    = PTR_W + 1;
   localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(3'd4);
   localparam logic [ADDR_W-1:0] WORD_MSK = ~ADDR_W'(2'd3);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] pc_r;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [15:0]       redir_count_r;
   logic [31:0]       instr_mem_r [DEPTH];
   logic [ADDR_W-1:0] pc4_mem_r   [DEPTH];

   logic              redir_accept_s;
   logic              pop_s;
   logic              fetch_s;
   logic [ADDR_W-1:0] pc_plus4_s;
   logic [ADDR_W-1:0] target_s;

   // Handshake decode: a redirect or reset suppresses fetching; a full FIFO fetches only if it is draining.
   always_comb begin
      redir_accept_s = redir_valid && (redir_kind != 2'd3) && !rst;
      pop_s          = (count_r != {CNT_W{1'b0}}) && dec_ready;
      fetch_s        = !rst && !redir_accept_s && ((count_r != FULL_CNT) || pop_s);
      pc_plus4_s     = pc_r + PC_STEP;
   end

   // Redirect target selection; the reserved kind never reaches the PC because it is not accepted.
   always_comb begin
      target_s = pc_r;
      case (redir_kind)
         2'd0:    target_s = redir_pc4 + {{(ADDR_W-18){redir_imm[15]}}, redir_imm, 2'b00};
         2'd1:    target_s = {redir_pc4[ADDR_W-1:28], redir_idx, 2'b00};
         2'd2:    target_s = redir_reg & WORD_MSK;
         default: target_s = pc_r;
      endcase
   end

   // PC, FIFO pointers/occupancy and the redirect counter; a redirect flushes and discards any pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r          <= RESET_PC;
         wr_ptr_r      <= {PTR_W{1'b0}};
         rd_ptr_r      <= {PTR_W{1'b0}};
         count_r       <= {CNT_W{1'b0}};
         redir_count_r <= 16'd0;
      end else if (redir_accept_s) begin
         pc_r     <= target_s;
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         if (redir_count_r != 16'hFFFF) begin
            redir_count_r <= redir_count_r + 16'd1;
         end
      end else begin
         if (fetch_s) begin
            pc_r     <= pc_plus4_s;
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         case ({fetch_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage: payload needs no reset since occupancy gates its visibility.
   always_ff @(posedge clk) begin
      if (fetch_s) begin
         instr_mem_r[wr_ptr_r] <= imem_rdata;
         pc4_mem_r[wr_ptr_r]   <= pc_plus4_s;
      end
   end

   assign imem_addr   = pc_r;
   assign imem_en     = fetch_s;
   assign dec_valid   = (count_r != {CNT_W{1'b0}});
   assign dec_instr   = instr_mem_r[rd_ptr_r];
   assign dec_pc4     = pc4_mem_r[rd_ptr_r];
   assign redir_count = redir_count_r;

endmodule
